spi_adc_responder: RTL and testbench

SPI responder that emulates the sonar receive-chain ADC at the far end of each `spi_con` controller. It drives `cipo` (`chip_data_out`) in response to `dclk`/`cs` from the controller. Samples come from a small internal FIFO fed by a stimulus or loopback source. It lets the receive path (`spi_con` → `receive_beamformer` → echo detection) run in loopback on the board and in simulation without physical ADCs.

---
 rtl/sonar_spi_pkg.sv | 16 +
 rtl/spi_adc_responder_if.sv | 34 +++
 rtl/sample_fifo.sv | 60 ++++++
 rtl/spi_adc_responder.sv | 195 +++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sonar_spi_pkg.sv
// Shared types and constants for the sonar SPI receive-chain models.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sonar_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ADC_SAMPLE_WIDTH = 12;
  localparam int ADC_FRAME_WIDTH  = 16;
  localparam int ADC_LEAD_ZEROS   = ADC_FRAME_WIDTH - ADC_SAMPLE_WIDTH;

endpackage

// File: rtl/spi_adc_responder_if.sv
// Sample feed plus SPI pins (dclk, cs, cipo) between a controller/stimulus side and the ADC responder.
// Latency: n/a (wires only).
// Backpressure: none; sample pushes are fire-and-forget, SPI timing is owned by the controller.
interface spi_adc_responder_if
  import sonar_spi_pkg::*;
#(
  parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH
) ();

  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid_in;
  logic                    chip_clk_in;
  logic                    chip_sel_in;
  logic                    chip_data_out;

  // Controller / stimulus side
  modport master (
    output sample_in,
    output sample_valid_in,
    output chip_clk_in,
    output chip_sel_in,
    input  chip_data_out
  );

  // Responder side
  modport slave (
    input  sample_in,
    input  sample_valid_in,
    input  chip_clk_in,
    input  chip_sel_in,
    output chip_data_out
  );

endinterface

// File: rtl/sample_fifo.sv
// Small circular sample buffer with occupancy count; head is visible combinationally.
// Latency: pushed data is readable at the head one cycle after the push.
// Backpressure: none upstream; a push on full is dropped unless a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_dat,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so push-on-full is accepted when paired with a pop.
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating a receive-chain ADC: serves FIFO samples MSB-first on cipo per cs-low frame.
// Latency: first bit 2 clk_in after cs fall, each next bit within 2 clk_in of dclk fall (+2 with SPI_ADC_RESPONDER_SYNC_EN).
// Backpressure: none; pushes on a full FIFO are dropped (overflow_out), empty frames repeat the last sample (underrun_out).
import sonar_spi_pkg::*;

module spi_adc_responder #(
  parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
  parameter int FRAME_WIDTH  = ADC_FRAME_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  spi_adc_responder_if.slave   bus,
  output logic                 frame_done_out,
  output logic                 underrun_out,
  output logic                 overflow_out,
  output logic                 busy_out
);

  localparam int CNT_W = $clog2(FRAME_WIDTH + 1);

  logic                    w_cs_pin;
  logic                    w_clk_pin;
  logic                    r_cs_q;
  logic                    r_cs_prev;
  logic                    r_clk_q;
  logic                    r_clk_prev;
  logic                    w_cs_fall;
  logic                    w_cs_rise;
  logic                    w_clk_rise;
  logic                    w_clk_fall;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [FRAME_WIDTH-1:0]  r_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [SAMPLE_WIDTH-1:0] r_last;
  logic                    r_frame_done;
  logic                    r_underrun;
  logic                    r_overflow;

  logic                    w_load;
  logic                    w_pop;
  logic                    w_shift;
  logic                    w_cnt_inc;
  logic                    w_frame_done;
  logic                    w_underrun;
  logic                    w_overflow;
  logic [SAMPLE_WIDTH-1:0] w_load_word;

  logic [SAMPLE_WIDTH-1:0] w_fifo_head;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

`ifdef SPI_ADC_RESPONDER_SYNC_EN
  logic r_cs_meta, r_cs_sync, r_clk_meta, r_clk_sync;

  // Two-flop synchronizers for controller pins arriving from another clock domain.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cs_meta  <= 1'b0;
      r_cs_sync  <= 1'b0;
      r_clk_meta <= 1'b0;
      r_clk_sync <= 1'b0;
    end else begin
      r_cs_meta  <= bus.chip_sel_in;
      r_cs_sync  <= r_cs_meta;
      r_clk_meta <= bus.chip_clk_in;
      r_clk_sync <= r_clk_meta;
    end
  end

  assign w_cs_pin  = r_cs_sync;
  assign w_clk_pin = r_clk_sync;
`else
  assign w_cs_pin  = bus.chip_sel_in;
  assign w_clk_pin = bus.chip_clk_in;
`endif

  // Input register plus delayed copy for edge detection. Clearing to 0 means a cs held low
  // across reset does not look like a fresh frame start.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cs_q     <= 1'b0;
      r_cs_prev  <= 1'b0;
      r_clk_q    <= 1'b0;
      r_clk_prev <= 1'b0;
    end else begin
      r_cs_q     <= w_cs_pin;
      r_cs_prev  <= r_cs_q;
      r_clk_q    <= w_clk_pin;
      r_clk_prev <= r_clk_q;
    end
  end

  assign w_cs_fall  =  r_cs_prev  & ~r_cs_q;
  assign w_cs_rise  = ~r_cs_prev  &  r_cs_q;
  assign w_clk_rise = ~r_clk_prev &  r_clk_q;
  assign w_clk_fall =  r_clk_prev & ~r_clk_q;

  // Empty FIFO at frame start: no pop, the frame repeats the last served sample.
  assign w_fifo_empty = (w_fifo_count == '0);
  assign w_load_word  = w_fifo_empty ? r_last : w_fifo_head;
  assign w_overflow   = bus.sample_valid_in & w_fifo_full & ~w_pop;

  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_push     (bus.sample_valid_in),
    .i_push_dat (bus.sample_in),
    .i_pop      (w_pop),
    .o_head_dat (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_count    (w_fifo_count)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath controls; cs rise takes priority so an aborted frame never reports done.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_underrun   = 1'b0;
    w_shift      = 1'b0;
    w_cnt_inc    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_load      = 1'b1;
          w_pop       = ~w_fifo_empty;
          w_underrun  = w_fifo_empty;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
        end else if (w_clk_rise) begin
          w_cnt_inc = 1'b1;
          if (r_bit_cnt == CNT_W'(FRAME_WIDTH - 1)) begin
            w_frame_done = 1'b1;
            w_state_nxt  = DONE;
          end
        end else if (w_clk_fall && (r_bit_cnt < CNT_W'(FRAME_WIDTH))) begin
          w_shift = 1'b1;
        end
      end
      DONE: begin
        if (w_cs_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter, last-sample memory and registered status pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_last       <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift   <= FRAME_WIDTH'(w_load_word);
        r_bit_cnt <= '0;
        r_last    <= w_load_word;
      end else begin
        if (w_shift)   r_shift   <= {r_shift[FRAME_WIDTH-2:0], 1'b0};
        if (w_cnt_inc) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      r_frame_done <= w_frame_done;
      r_underrun   <= w_underrun;
      r_overflow   <= w_overflow;
    end
  end

  assign bus.chip_data_out = (r_state == SHIFT) & r_shift[FRAME_WIDTH-1];
  assign busy_out          = (r_state == SHIFT);
  assign frame_done_out    = r_frame_done;
  assign underrun_out      = r_underrun;
  assign overflow_out      = r_overflow;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench: behaves as an spi_con controller and checks served words and status pulses.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_adc_responder;

  localparam int HALF = 4;  // dclk half-period in clk_in cycles

  logic clk_in;
  logic rst_in;
  logic frame_done_out;
  logic underrun_out;
  logic overflow_out;
  logic busy_out;

  int n_checks;
  int n_errors;
  int n_done;
  int n_under;
  int n_over;

  spi_adc_responder_if bus ();

  spi_adc_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .bus            (bus),
    .frame_done_out (frame_done_out),
    .underrun_out   (underrun_out),
    .overflow_out   (overflow_out),
    .busy_out       (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Running tallies of the one-cycle status pulses.
  initial begin
    n_done  = 0;
    n_under = 0;
    n_over  = 0;
  end
  always @(posedge clk_in) begin
    if (frame_done_out) n_done++;
    if (underrun_out)   n_under++;
    if (overflow_out)   n_over++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    @(posedge clk_in); #1;
    bus.sample_valid_in = 1'b1;
    bus.sample_in       = v;
    @(posedge clk_in); #1;
    bus.sample_valid_in = 1'b0;
  endtask

  // One controller frame of nbits dclk cycles; cipo captured just before each dclk rise.
  // Optionally pushes a sample in the cycle the responder sees the cs fall.
  task automatic frame(input int nbits, input logic do_push, input logic [11:0] pv,
                       output logic [15:0] w);
    w = '0;
    @(posedge clk_in); #1;
    bus.chip_sel_in = 1'b0;
    wait_cyc(1);
    if (do_push) begin
      bus.sample_valid_in = 1'b1;
      bus.sample_in       = pv;
    end
    wait_cyc(1);
    bus.sample_valid_in = 1'b0;
    wait_cyc(HALF - 2);
    for (int i = 0; i < nbits; i++) begin
      w = {w[14:0], bus.chip_data_out};
      bus.chip_clk_in = 1'b1;
      wait_cyc(HALF);
      bus.chip_clk_in = 1'b0;
      wait_cyc(HALF);
    end
    bus.chip_sel_in = 1'b1;
    wait_cyc(HALF + 2);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    wait_cyc(3);
    rst_in = 1'b0;
    wait_cyc(2);
  endtask

  logic [15:0] w;
  int d0, u0, o0;

  initial begin
    n_checks            = 0;
    n_errors            = 0;
    rst_in              = 1'b1;
    bus.sample_in       = '0;
    bus.sample_valid_in = 1'b0;
    bus.chip_clk_in     = 1'b0;
    bus.chip_sel_in     = 1'b1;
    wait_cyc(3);

    // Reset state
    check("rst_cipo",     bus.chip_data_out, 0);
    check("rst_done",     frame_done_out, 0);
    check("rst_underrun", underrun_out, 0);
    check("rst_overflow", overflow_out, 0);
    check("rst_busy",     busy_out, 0);
    rst_in = 1'b0;
    wait_cyc(2);

    // Single sample
    d0 = n_done; u0 = n_under;
    push(12'hABC);
    frame(16, 1'b0, '0, w);
    check("f1_word", w, 16'h0ABC);
    check("f1_done", n_done - d0, 1);
    check("f1_under", n_under - u0, 0);
    check("f1_busy", busy_out, 0);

    // Three queued samples, in order
    d0 = n_done; u0 = n_under;
    push(12'h001); push(12'hFFF); push(12'h800);
    frame(16, 1'b0, '0, w); check("q_word0", w, 16'h0001);
    frame(16, 1'b0, '0, w); check("q_word1", w, 16'h0FFF);
    frame(16, 1'b0, '0, w); check("q_word2", w, 16'h0800);
    check("q_done", n_done - d0, 3);
    check("q_under", n_under - u0, 0);

    // Underrun after reset, then last-sample repeat
    do_reset();
    u0 = n_under;
    frame(16, 1'b0, '0, w); check("ur_word0", w, 16'h0000);
    frame(16, 1'b0, '0, w); check("ur_word1", w, 16'h0000);
    check("ur_under2", n_under - u0, 2);
    push(12'h123);
    u0 = n_under;
    frame(16, 1'b0, '0, w); check("ur_word2", w, 16'h0123);
    check("ur_under_none", n_under - u0, 0);
    frame(16, 1'b0, '0, w); check("ur_repeat", w, 16'h0123);
    check("ur_under1", n_under - u0, 1);

    // Overflow on the 5th push into a depth-4 FIFO
    do_reset();
    o0 = n_over;
    push(12'hA01); push(12'hA02); push(12'hA03); push(12'hA04);
    wait_cyc(2);
    check("ov_none", n_over - o0, 0);
    push(12'hA05);
    wait_cyc(2);
    check("ov_once", n_over - o0, 1);
    u0 = n_under;
    frame(16, 1'b0, '0, w); check("ov_word0", w, 16'h0A01);
    frame(16, 1'b0, '0, w); check("ov_word1", w, 16'h0A02);
    frame(16, 1'b0, '0, w); check("ov_word2", w, 16'h0A03);
    frame(16, 1'b0, '0, w); check("ov_word3", w, 16'h0A04);
    check("ov_under", n_under - u0, 0);

    // Push coinciding with a frame start on an empty FIFO
    u0 = n_under;
    frame(16, 1'b1, 12'h5A5, w); check("pp_word0", w, 16'h0A04);
    check("pp_under", n_under - u0, 1);
    frame(16, 1'b0, '0, w); check("pp_word1", w, 16'h05A5);
    check("pp_under_none", n_under - u0, 1);

    // Abort after 7 dclk cycles
    push(12'h456); push(12'h789);
    d0 = n_done;
    frame(7, 1'b0, '0, w);
    check("ab_partial", w, 16'h0002);
    check("ab_done", n_done - d0, 0);
    check("ab_busy", busy_out, 0);
    check("ab_cipo", bus.chip_data_out, 0);
    frame(16, 1'b0, '0, w); check("ab_next", w, 16'h0789);

    // Reset mid-frame with two entries queued
    push(12'h111); push(12'h222);
    @(posedge clk_in); #1;
    bus.chip_sel_in = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < 3; i++) begin
      bus.chip_clk_in = 1'b1; wait_cyc(HALF);
      bus.chip_clk_in = 1'b0; wait_cyc(HALF);
    end
    check("mr_busy_pre", busy_out, 1);
    rst_in = 1'b1;
    wait_cyc(2);
    check("mr_cipo", bus.chip_data_out, 0);
    check("mr_busy", busy_out, 0);
    check("mr_done", frame_done_out, 0);
    check("mr_under", underrun_out, 0);
    check("mr_over", overflow_out, 0);
    bus.chip_sel_in = 1'b1;
    wait_cyc(2);
    rst_in = 1'b0;
    wait_cyc(3);
    u0 = n_under;
    frame(16, 1'b0, '0, w); check("mr_word", w, 16'h0000);
    check("mr_underrun", n_under - u0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
